warmboot_controller: RTL
========================

# warmboot_controller

Fabric-side responder for warm-boot requests. User designs raise a boot request with a slot number. This block filters the request and latches the slot. It then holds the user fabric in reset, asks the configuration loader to reload the bitstream from that slot's flash offset, and releases the fabric afterwards. It sits between the user-design trigger signals and the bitstream loader, and it is the sole driver of the fabric reset that user designs see.

## Interface
Parameters:
- SLOT_BITS, 4: width of the slot number.
- ADDR_W, 24: width of the configuration address.
- SLOT_SHIFT, 20: log2 of the slot size in bytes (1 MiB slots). Constraint: SLOT_BITS+SLOT_SHIFT <= ADDR_W.
- BOOT_FILTER, 4: consecutive high samples of boot_i needed to accept a request (>=1).
- RESET_HOLD, 16: cycles fabric_rst_o stays high after the load completes (>=1).
- TIMEOUT, 65535: maximum cycles to wait for loader completion (>=1).

Ports:
- clk, input, 1: clock.
- RESET, input, 1: synchronous, active-high block reset.
- slot_i, input, SLOT_BITS: requested slot. Sampled only on the acceptance cycle.
- boot_i, input, 1: boot request level from the user design.
- fabric_rst_o, output, 1: synchronous active-high reset to the user fabric.
- cfg_req_o, output, 1: load request to the loader. Held until acknowledged.
- cfg_addr_o, output, ADDR_W: load start address, equal to slot << SLOT_SHIFT.
- cfg_ack_i, input, 1: loader accepted the request.
- cfg_done_i, input, 1: single-cycle pulse, load finished OK.
- cfg_err_i, input, 1: single-cycle pulse, load failed.
- busy_o, output, 1: high in REQ, WAIT and HOLD.
- last_slot_o, output, SLOT_BITS: last accepted slot.
- err_o, output, 1: sticky error flag.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DISARM. All outputs are registered.
- RESET value of every output and the state:
  - state HOLD, hold counter 0.
  - fabric_rst_o=1, cfg_req_o=0, cfg_addr_o=0.
  - busy_o=1, last_slot_o=0, err_o=0.
- IDLE (armed):
  - A filter counter increments each cycle boot_i=1 and clears on any boot_i=0.
  - When the count reaches BOOT_FILTER: latch slot_i into last_slot_o, set cfg_addr_o = zero-extended slot << SLOT_SHIFT (upper bits 0), set fabric_rst_o=1, set cfg_req_o=1, go to REQ.
- REQ: hold cfg_req_o and cfg_addr_o. When cfg_ack_i=1: clear cfg_req_o, clear the watchdog, go to WAIT. cfg_done_i and cfg_err_i are ignored in REQ.
- WAIT:
  - cfg_done_i=1: clear err_o, go to HOLD.
  - cfg_err_i=1, or the watchdog reaches TIMEOUT: set err_o, go to HOLD.
  - done and err in the same cycle: err wins.
- HOLD: fabric_rst_o stays 1 for RESET_HOLD cycles counted from HOLD entry, then clears to 0 and the block goes to DISARM.
- DISARM: wait for one sample of boot_i=0, then go to IDLE with the filter cleared. This prevents a stuck-high boot_i from causing a reboot loop.
- boot_i and slot_i are ignored outside IDLE. A second request therefore needs boot_i low, then high again for BOOT_FILTER cycles.
- RESET mid-operation: abort immediately to reset values, including cfg_req_o=0. The loader must tolerate an abandoned request.

## Timing
- Request acceptance: first high sample of boot_i at cycle t0 gives fabric_rst_o=1 and cfg_req_o=1 visible from cycle t0+BOOT_FILTER.
- Handshake: cfg_ack_i sampled high in cycle t gives cfg_req_o=0 from t+1.
- Completion: cfg_done_i in cycle t gives HOLD from t+1, and fabric_rst_o falls at t+1+RESET_HOLD.
- Watchdog: counts 1..TIMEOUT starting in the first WAIT cycle. With no done or err, the error path is taken after the TIMEOUT-th WAIT cycle. The counter saturates and never wraps.
- After RESET deasserts, fabric_rst_o remains high for RESET_HOLD cycles, then the block enters DISARM.
- Counter widths are $clog2 of (max value + 1), with no overflow.

## Test plan
- Power-up:
  - Stimulus: RESET high for 3 cycles, boot_i=0.
  - Required: fabric_rst_o=1 for 16 cycles after RESET falls, then 0; state IDLE after one boot_i=0 sample; busy_o=0.
- Nominal boot to slot 5:
  - Stimulus: boot_i high from t0, slot_i=5.
  - Required: at t0+4, cfg_req_o=1, cfg_addr_o=0x500000, last_slot_o=5.
  - Stimulus: ack after 2 cycles, done 10 cycles later.
  - Required: fabric_rst_o falls 16 cycles after done+1; err_o=0.
- Glitch filter:
  - Stimulus: boot_i high for 3 cycles, low for 1, then high for 4.
  - Required: only the second burst is accepted; no cfg_req_o after the first burst.
- Loader failure:
  - Stimulus: cfg_err_i pulse in WAIT; separately, cfg_done_i and cfg_err_i in the same cycle.
  - Required: err_o=1 in both cases, HOLD is still entered, and err_o clears after a later successful boot.
- Timeout and stuck boot:
  - Stimulus: TIMEOUT=8 with no done.
  - Required: err_o rises after the 8th WAIT cycle.
  - Stimulus: boot_i held high throughout.
  - Required: no second request until boot_i drops low.
- Reset mid-load:
  - Stimulus: RESET asserted in REQ with slot 3.
  - Required: cfg_req_o=0, last_slot_o=0 and fabric_rst_o=1 on the next cycle.

Source files
------------

// File: rtl/warmboot_controller.sv
// Warm-boot responder: filters the user boot request, holds the fabric in reset,
// asks the configuration loader to reload from the slot's flash offset, then releases the fabric.
module warmboot_controller #(
    parameter int SLOT_BITS   = 4,
    parameter int ADDR_W      = 24,
    parameter int SLOT_SHIFT  = 20,
    parameter int BOOT_FILTER = 4,
    parameter int RESET_HOLD  = 16,
    parameter int TIMEOUT     = 65535
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic [SLOT_BITS-1:0] slot_i,
    input  logic                 boot_i,
    output logic                 fabric_rst_o,
    output logic                 cfg_req_o,
    output logic [ADDR_W-1:0]    cfg_addr_o,
    input  logic                 cfg_ack_i,
    input  logic                 cfg_done_i,
    input  logic                 cfg_err_i,
    output logic                 busy_o,
    output logic [SLOT_BITS-1:0] last_slot_o,
    output logic                 err_o,
    output logic [2:0]           debug_state
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_DISARM = 3'd4;

    localparam int FILT_W = $clog2(BOOT_FILTER + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(BOOT_FILTER - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT);

    logic [2:0]        state;
    logic [FILT_W-1:0] filt_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WDOG_W-1:0] wdog_cnt;

    assign debug_state = state;

    // cfg_req_o acts as a valid held steady (with cfg_addr_o) until cfg_ack_i is
    // sampled high; the transfer completes on that edge and the request drops next cycle.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state        <= ST_HOLD;
            filt_cnt     <= '0;
            hold_cnt     <= '0;
            wdog_cnt     <= '0;
            fabric_rst_o <= 1'b1;
            cfg_req_o    <= 1'b0;
            cfg_addr_o   <= '0;
            busy_o       <= 1'b1;
            last_slot_o  <= '0;
            err_o        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!boot_i) begin
                        filt_cnt <= '0;
                    end else if (filt_cnt == FILT_LAST) begin
                        filt_cnt     <= '0;
                        last_slot_o  <= slot_i;
                        cfg_addr_o   <= ADDR_W'(slot_i) << SLOT_SHIFT;
                        fabric_rst_o <= 1'b1;
                        cfg_req_o    <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= ST_REQ;
                    end else begin
                        filt_cnt <= filt_cnt + FILT_W'(1);
                    end
                end
                ST_REQ: begin
                    if (cfg_ack_i) begin
                        cfg_req_o <= 1'b0;
                        wdog_cnt  <= '0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An error pulse outranks a simultaneous done pulse.
                    if (cfg_err_i || wdog_cnt == WDOG_LAST) begin
                        err_o    <= 1'b1;
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                    end else if (cfg_done_i) begin
                        err_o    <= 1'b0;
                        hold_cnt <= '0;
                        state    <= ST_HOLD;
                    end else if (wdog_cnt != WDOG_MAX) begin
                        wdog_cnt <= wdog_cnt + WDOG_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        fabric_rst_o <= 1'b0;
                        busy_o       <= 1'b0;
                        state        <= ST_DISARM;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_DISARM: begin
                    // A boot line stuck high must not retrigger: require one low sample first.
                    if (!boot_i) begin
                        filt_cnt <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    hold_cnt     <= '0;
                    fabric_rst_o <= 1'b1;
                    cfg_req_o    <= 1'b0;
                    busy_o       <= 1'b1;
                    state        <= ST_HOLD;
                end
            endcase
        end
    end

endmodule
